// File: rtl/hazard_ctrl_if.sv
// Pipeline-register view consumed by the hazard unit and the controls it drives back.
// The master side is the pipeline datapath; the slave side is hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       if_id_rs1;
  logic [4:0]       if_id_rs2;
  logic             if_id_use_rs1;
  logic             if_id_use_rs2;
  logic [4:0]       id_ex_rs1;
  logic [4:0]       id_ex_rs2;
  logic [4:0]       id_ex_rd;
  logic             id_ex_memread;
  logic [4:0]       ex_mem_rd;
  logic             ex_mem_regwrite;
  logic [4:0]       mem_wb_rd;
  logic             mem_wb_regwrite;
  logic             branch_taken;
  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic             pc_write_en;
  logic             if_id_write_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output if_id_rs1, if_id_rs2, if_id_use_rs1, if_id_use_rs2,
           id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_memread,
           ex_mem_rd, ex_mem_regwrite, mem_wb_rd, mem_wb_regwrite, branch_taken,
    input  forward_a, forward_b, pc_write_en, if_id_write_en,
           if_id_flush, id_ex_flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  if_id_rs1, if_id_rs2, if_id_use_rs1, if_id_use_rs2,
           id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_memread,
           ex_mem_rd, ex_mem_regwrite, mem_wb_rd, mem_wb_regwrite, branch_taken,
    output forward_a, forward_b, pc_write_en, if_id_write_en,
           if_id_flush, id_ex_flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage RV32 core: EX operand forwarding, load-use stall FSM,
// taken-branch flush control and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [1:0] REM_INIT = 2'(LOAD_STALL - 1);

  state_t           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic       lu;
  logic [1:0] fwd_a, fwd_b;
  logic       pc_we, ifid_we, ifid_fl, idex_fl;
  logic       stall_inc, flush_inc;

  always_comb begin
    fwd_a = 2'b00;
    if (hz.ex_mem_regwrite && hz.ex_mem_rd != '0 && hz.ex_mem_rd == hz.id_ex_rs1)
      fwd_a = 2'b10;
    else if (hz.mem_wb_regwrite && hz.mem_wb_rd != '0 && hz.mem_wb_rd == hz.id_ex_rs1)
      fwd_a = 2'b01;

    fwd_b = 2'b00;
    if (hz.ex_mem_regwrite && hz.ex_mem_rd != '0 && hz.ex_mem_rd == hz.id_ex_rs2)
      fwd_b = 2'b10;
    else if (hz.mem_wb_regwrite && hz.mem_wb_rd != '0 && hz.mem_wb_rd == hz.id_ex_rs2)
      fwd_b = 2'b01;
  end

  assign lu = hz.id_ex_memread && (hz.id_ex_rd != '0) &&
              ((hz.if_id_use_rs1 && hz.id_ex_rd == hz.if_id_rs1) ||
               (hz.if_id_use_rs2 && hz.id_ex_rd == hz.if_id_rs2));

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    pc_we     = 1'b1;
    ifid_we   = 1'b1;
    ifid_fl   = 1'b0;
    idex_fl   = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.branch_taken) begin
          ifid_fl   = 1'b1;
          idex_fl   = 1'b1;
          flush_inc = 1'b1;
        end else if (lu) begin
          pc_we     = 1'b0;
          ifid_we   = 1'b0;
          idex_fl   = 1'b1;
          stall_inc = 1'b1;
          if (LOAD_STALL > 1) begin
            state_d = STALL;
            rem_d   = REM_INIT;
          end
        end
      end
      STALL: begin
        // A branch resolving in EX squashes the instruction held in ID, so the stall is moot.
        if (hz.branch_taken) begin
          ifid_fl   = 1'b1;
          idex_fl   = 1'b1;
          flush_inc = 1'b1;
          rem_d     = '0;
          state_d   = RUN;
        end else begin
          pc_we     = 1'b0;
          ifid_we   = 1'b0;
          idex_fl   = 1'b1;
          stall_inc = 1'b1;
          rem_d     = rem_q - 2'd1;
          if (rem_q <= 2'd1) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      rem_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (stall_inc && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  // Outputs are combinational, so reset must override them directly rather than via state.
  always_comb begin
    hz.forward_a      = rst_n ? fwd_a   : 2'b00;
    hz.forward_b      = rst_n ? fwd_b   : 2'b00;
    hz.pc_write_en    = rst_n ? pc_we   : 1'b0;
    hz.if_id_write_en = rst_n ? ifid_we : 1'b0;
    hz.if_id_flush    = rst_n ? ifid_fl : 1'b1;
    hz.id_ex_flush    = rst_n ? idex_fl : 1'b1;
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule
